// File: rtl/seq_square_mult.sv
// seq_square_mult: sequential shift-add squarer / multiplier.
// Computes a*a (mode=0) or a*b (mode=1) on unsigned WIDTH-bit operands. One
// partial-product step is taken per clock, so a result takes WIDTH cycles
// after start is accepted, and the unit is occupied for WIDTH+1 cycles.
//
// Handshake: start is a request that is accepted only while busy=0 (IDLE).
// Acceptance latches mode/a/b and raises busy at the same edge. While busy=1
// start and all operand inputs are ignored. done pulses for exactly one cycle
// together with the new result, and busy is already low in that cycle, so a
// start held or raised during the done cycle is accepted at the next edge.
// busy and done are never high together.
module seq_square_mult #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 dbg_state
);

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t               state;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_next;
   logic [WIDTH-1:0]     mplier;
   logic [CW-1:0]        cnt;

   // Accumulator value after this step's conditional add; wraps modulo 2^(2*WIDTH)
   always_comb begin
      acc_next = acc;
      if (mplier[0]) begin
         acc_next = acc + mcand;
      end
   end

   // Controller and datapath: operand capture in IDLE, one shift-add step per RUN cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else begin
         // done is a pulse: it falls at the edge after it was set, whatever the state
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= {{WIDTH{1'b0}}, a};
                  mplier <= mode ? b : a;
                  acc    <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               // Last step: publish the sum including this step's add
               if (cnt == LAST) begin
                  result <= acc_next;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // State visibility for external checkers: 1 while in RUN
   assign dbg_state = (state == RUN);

endmodule
